ones_comp_checksum_checker: RTL and testbench
=============================================

# ones_comp_checksum_checker

Receive-side checker for the ones'-complement checksum formed by the end-around-carry adder. It accepts a frame of WIDTH-bit words, with the sender's checksum word as the final word, over a valid/ready stream. It folds each word into a running ones'-complement sum and reports whether the frame sums to all ones. It sits downstream of the checksum-generating adder path and closes the loop on that arithmetic.

## Interface
Parameters:
- WIDTH, 4: word width in bits; also the accumulator width.
- CNT_W, 8: width of the frame word counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_data and in_last are valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  frame word, including the checksum word.
- in_last  input  1  marks the final word of the frame.
- out_valid  output  1  frame result is presented.
- out_ready  input  1  consumer accepts the result.
- out_ok  output  1  1 when the final sum equals all ones.
- out_sum  output  WIDTH  final ones'-complement sum of the frame.
- out_count  output  CNT_W  number of words in the frame, saturating.

## Operation
- FSM has two states, ACCUM and RESULT. Reset enters ACCUM.
- ACCUM: in_ready=1, out_valid=0.
  - A word is accepted on the cycle in_valid && in_ready.
  - On acceptance: s = acc + in_data, computed at WIDTH+1 bits. Then acc <= s[WIDTH-1:0] + s[WIDTH]. The end-around-carry add never produces a second carry.
  - count <= count + 1, saturating at 2^CNT_W - 1.
- Last word (accepted with in_last=1): the sum and count including that word load into out_sum and out_count. out_ok <= (sum == all ones). FSM moves to RESULT. acc and count clear to 0.
- RESULT: in_ready=0, out_valid=1. out_sum, out_ok and out_count hold stable until out_valid && out_ready. On that handshake, FSM returns to ACCUM.
- Zero sums:
  - The accumulator starts at +0 (all zeros).
  - A frame whose sum is all zeros is a fail (out_ok=0).
  - A frame whose sum is negative zero (all ones) is a pass.
- Ignored inputs: in_data and in_last are don't-care when in_valid=0. out_ready is ignored in ACCUM.
- Single-word frame (in_last on the first word) is legal: out_count=1.

## Timing
- Reset values: in_ready=1, out_valid=0, out_ok=0, out_sum=0, out_count=0, acc=0, count=0.
- in_ready and out_valid decode directly from the FSM state and are registered-state outputs. There is no combinational path from in_valid or out_ready to either of them.
- Latency: last word accepted on edge N, so out_valid=1 from after edge N until the out handshake.
- Out handshake on edge M: out_valid=0 and in_ready=1 after edge M. The next frame's first word is accepted no earlier than edge M+1.
- Throughput: 1 word/cycle within a frame. There is one bubble cycle per frame, plus any out_ready stall.
- Backpressure: while out_ready=0, RESULT holds indefinitely and in_ready stays 0.
- rst_n low at any time, mid-frame or in RESULT: all state returns to reset values immediately. The partial frame is discarded and no result is emitted.
- Counter saturation does not affect the sum or out_ok.

## Structure
- Shared package ones_comp_pkg holds:
  - the state enum (ACCUM, RESULT);
  - the default constants WIDTH_DEF=4 and CNT_W_DEF=8.
- Sub-module ones_comp_add (parameter WIDTH) holds the end-around-carry adder.
  - Purely combinational: a, b in; y out.
  - Reused by the checksum generator side.
- The top level contains only the FSM, acc/count registers and output registers.

## Test plan
All scenarios use WIDTH=4.
- Simple pass: frame 0x3, 0xC(last) gives out_sum=0xF, out_ok=1, out_count=2, one cycle after the last word.
- Carry wrap: frame 0x9, 0x8, 0xD(last).
  - 9+8 gives acc=0x2, then 2+D gives 0xF.
  - Expect out_ok=1, out_count=3.
  - Separately, frame 0xF, 0xF(last) gives out_sum=0xF, out_ok=1.
- Fail cases:
  - Frame 0x9, 0x8, 0xC(last) gives out_sum=0xE, out_ok=0.
  - Single word 0x0(last) gives out_sum=0x0, out_ok=0, out_count=1.
- Backpressure: hold out_ready=0 for 3 cycles after the result.
  - out_valid stays 1 with stable outputs, and in_ready stays 0 while in_valid is held 1.
  - Raise out_ready: the next frame's first word is accepted one cycle after the handshake.
- Reset mid-frame: accept 0x5, 0x6, then pulse rst_n low asynchronously.
  - All outputs return to reset values and no out_valid appears.
  - A following frame 0x3, 0xC(last) then gives out_count=2, out_ok=1.
- Counter saturation: use a CNT_W=2 build and send 5 words ending so the sum is 0xF. Expect out_count=3 and out_ok=1.

Source files
------------

// File: rtl/ones_comp_pkg.sv
// ones_comp_pkg: shared state enum and default widths for the ones'-complement checksum blocks
package ones_comp_pkg;
    typedef enum logic {ACCUM, RESULT} state_t;
    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/ones_comp_add.sv
// ones_comp_add: combinational end-around-carry adder
// a, b: addends; y: ones'-complement sum
module ones_comp_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH:0] s;
    // folding the carry back in cannot carry again: s[WIDTH-1:0] is at most 2^WIDTH-2 when s[WIDTH]=1
    assign s = {1'b0, a} + {1'b0, b};
    assign y = s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, s[WIDTH]};
endmodule

// File: rtl/ones_comp_checksum_checker.sv
// ones_comp_checksum_checker: folds a valid/ready frame into a ones'-complement sum and flags all-ones
// in_*: frame word stream, in_last marks the checksum word
// out_*: registered result (sum, pass flag, saturating word count) held until out_ready
module ones_comp_checksum_checker
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ok,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, sum, out_sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, out_count_d;
    logic             out_ok_d, fire, done;

    ones_comp_add #(.WIDTH(WIDTH)) u_add (.a(acc_q), .b(in_data), .y(sum));

    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == RESULT;

    always_comb begin
        fire        = in_valid && in_ready;
        done        = fire && in_last;
        cnt_inc     = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d     = in_ready ? (done ? RESULT : ACCUM) : (out_ready ? ACCUM : RESULT);
        acc_d       = fire ? (in_last ? '0 : sum) : acc_q;
        cnt_d       = fire ? (in_last ? '0 : cnt_inc) : cnt_q;
        out_sum_d   = done ? sum : out_sum;
        out_ok_d    = done ? &sum : out_ok;
        out_count_d = done ? cnt_inc : out_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_sum   <= '0;
            out_ok    <= 1'b0;
            out_count <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_sum   <= out_sum_d;
            out_ok    <= out_ok_d;
            out_count <= out_count_d;
        end
    end
endmodule

// File: tb/tb_ones_comp_checksum_checker.sv
// tb_ones_comp_checksum_checker: directed frame table plus backpressure, reset and saturation sequences
module tb_ones_comp_checksum_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_ok;
    logic [3:0] out_sum;
    logic [7:0] out_count;
    logic       in_ready2, out_valid2, out_ok2;
    logic [3:0] out_sum2;
    logic [1:0] out_count2;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    ones_comp_checksum_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_ok(out_ok), .out_sum(out_sum), .out_count(out_count)
    );

    ones_comp_checksum_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_ok(out_ok2), .out_sum(out_sum2), .out_count(out_count2)
    );

    typedef struct {
        int         n;
        logic [3:0] w[5];
        logic [3:0] sum;
        logic       ok;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [3:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 8'(in_ready), 8'h1);
        tick();
        in_valid = 1'b0;
        in_data  = 4'h0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        chk({name, "_outv_after"}, 8'(out_valid), 8'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_outv_clr"}, 8'(out_valid), 8'h0);
        chk({name, "_inrdy_set"}, 8'(in_ready), 8'h1);
    endtask

    initial begin
        vecs[0] = '{2, '{4'h3, 4'hC, 4'h0, 4'h0, 4'h0}, 4'hF, 1'b1, 8'd2, 2'd2};
        vecs[1] = '{3, '{4'h9, 4'h8, 4'hD, 4'h0, 4'h0}, 4'hF, 1'b1, 8'd3, 2'd3};
        vecs[2] = '{2, '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0}, 4'hF, 1'b1, 8'd2, 2'd2};
        vecs[3] = '{3, '{4'h9, 4'h8, 4'hC, 4'h0, 4'h0}, 4'hE, 1'b0, 8'd3, 2'd3};
        vecs[4] = '{1, '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, 4'h0, 1'b0, 8'd1, 2'd1};
        vecs[5] = '{2, '{4'h7, 4'h9, 4'h0, 4'h0, 4'h0}, 4'h1, 1'b0, 8'd2, 2'd2};
        vecs[6] = '{4, '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0}, 4'hF, 1'b1, 8'd4, 2'd3};
        vecs[7] = '{5, '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0}, 4'hF, 1'b1, 8'd5, 2'd3};

        #2;
        chk("rst_in_ready", 8'(in_ready), 8'h1);
        chk("rst_out_valid", 8'(out_valid), 8'h0);
        chk("rst_out_ok", 8'(out_ok), 8'h0);
        chk("rst_out_sum", 8'(out_sum), 8'h0);
        chk("rst_out_count", out_count, 8'h0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < vecs[v].n; k++) send_word(vecs[v].w[k], k == vecs[v].n - 1);
            chk($sformatf("v%0d_sum", v), 8'(out_sum), 8'(vecs[v].sum));
            chk($sformatf("v%0d_ok", v), 8'(out_ok), 8'(vecs[v].ok));
            chk($sformatf("v%0d_cnt", v), out_count, vecs[v].cnt);
            chk($sformatf("v%0d_cnt_sat", v), 8'(out_count2), 8'(vecs[v].cnt2));
            chk($sformatf("v%0d_ok_sat", v), 8'(out_ok2), 8'(vecs[v].ok));
            drain($sformatf("v%0d", v));
        end

        send_word(4'h3, 1'b0);
        send_word(4'hC, 1'b1);
        in_valid = 1'b1;
        in_data  = 4'h5;
        in_last  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_outv", c), 8'(out_valid), 8'h1);
            chk($sformatf("bp%0d_inrdy", c), 8'(in_ready), 8'h0);
            chk($sformatf("bp%0d_sum", c), 8'(out_sum), 8'hF);
            chk($sformatf("bp%0d_ok", c), 8'(out_ok), 8'h1);
            chk($sformatf("bp%0d_cnt", c), out_count, 8'd2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_hs_outv", 8'(out_valid), 8'h0);
        chk("bp_hs_inrdy", 8'(in_ready), 8'h1);
        tick();
        in_data = 4'hA;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_next_outv", 8'(out_valid), 8'h1);
        chk("bp_next_sum", 8'(out_sum), 8'hF);
        chk("bp_next_cnt", out_count, 8'd2);
        drain("bp_next");

        send_word(4'h5, 1'b0);
        send_word(4'h6, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_inrdy", 8'(in_ready), 8'h1);
        chk("mrst_outv", 8'(out_valid), 8'h0);
        chk("mrst_sum", 8'(out_sum), 8'h0);
        chk("mrst_ok", 8'(out_ok), 8'h0);
        chk("mrst_cnt", out_count, 8'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mrst_idle%0d_outv", c), 8'(out_valid), 8'h0);
        end
        send_word(4'h3, 1'b0);
        send_word(4'hC, 1'b1);
        chk("mrst_next_sum", 8'(out_sum), 8'hF);
        chk("mrst_next_ok", 8'(out_ok), 8'h1);
        chk("mrst_next_cnt", out_count, 8'd2);
        drain("mrst_next");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
